conv_kernel_3x3_acc: RTL and testbench
======================================

Name: conv_kernel_3x3_acc

Overview:
- Parametrised successor to the fixed 3x3, 2-output-channel convolution kernel.
- Computes OUT_CH parallel 3x3 signed dot products per input beat, then accumulates them across input channels framed by first/last tags.
- Emits one saturated result per output channel per frame.
- Sits between the line-buffer/window generator and the requantisation/pooling stage.

Parameters:
- DATA_W, 8, signed activation width per window tap
- WGT_W, 8, signed weight width per tap
- OUT_CH, 2, number of output channels computed in parallel (>=1)
- ACC_W, 24, signed accumulator/output width per channel (>= DATA_W+WGT_W+4)

Ports:
- sclk  in  1  system clock
- s_rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  window beat valid
- in_first  in  1  beat is first input channel of a frame
- in_last  in  1  beat is last input channel of a frame
- data_in  in  9*DATA_W  window taps; tap k at [k*DATA_W +: DATA_W], k = row*3+col
- weight_in  in  OUT_CH*9*WGT_W  weights; channel c tap k at [(c*9+k)*WGT_W +: WGT_W]
- out_valid  out  1  one-cycle pulse, result valid
- out_data  out  OUT_CH*ACC_W  channel c result at [c*ACC_W +: ACC_W], signed
- out_sat  out  OUT_CH  per-channel flag: saturation occurred within this frame

Behaviour:
- One clock (sclk); reset asynchronous, active-low (s_rst_n). No backpressure; a beat is accepted every cycle in_valid=1. Gaps (in_valid=0) are allowed anywhere, including mid-frame.
- Reset values: out_valid=0, out_data=0, out_sat=0, all pipeline valid/tag registers=0, accumulators=0, sticky sat flags=0.
- Pipeline (all stages registered; valid, first and last travel alongside data):
  - S1: 9*OUT_CH signed products, width DATA_W+WGT_W.
  - S2: three row partial sums per channel, +2 bits.
  - S3: 9-tap sum per channel, width DATA_W+WGT_W+4, sign-extended to ACC_W+1.
  - S4: accumulate/output.
- Latency: out_valid asserts exactly 4 cycles after the cycle in which in_valid=1 with in_last=1 was sampled.
- S4 on a valid beat:
  - first=1: acc = sum; sat flag = 0.
  - Otherwise: acc = acc + sum.
- S4 arithmetic is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A clamp sets the channel's sticky sat flag; the flag clears on the next first beat.
- When last=1 on a valid S4 beat:
  - out_data <= clamped acc; out_sat <= sticky flag including this beat; out_valid <= 1 for one cycle.
  - out_data holds until the next output.
- first=1 and last=1 on the same beat: single-channel frame; output = clamped sum.
- last without a preceding first: accumulates onto the current acc (0 after reset).
- first while a frame is open: the open frame is discarded silently and acc restarts.
- in_first/in_last are ignored when in_valid=0.
- Reset asserted mid-frame: everything returns to reset values immediately; no stale out_valid after release.

Optional Feature:
- Macro CONV_KERNEL_RELU_EN.
- Defined: at S4 output, negative clamped results are written as 0 (out_sat unaffected); latency unchanged.
- Undefined: signed results pass through unmodified.

Test Plan:
- Single-channel frame: all taps=1, ch0 weights=1, ch1 weights=-1, in_first=in_last=1 -> 4 cycles later out_valid=1, ch0=9, ch1=-9, out_sat=0.
- 3-channel frame with gaps: taps=2, all weights=3, beats first/mid/last with one idle cycle between each -> single out_valid, both channels=162, out_valid 4 cycles after the last beat.
- Saturation: taps=-128, weights=-128, first beat plus 59 further beats, last on the 60th -> out_data=8388607 (0x7FFFFF) both channels, out_sat=2'b11. Next frame, first=last with taps=0 -> out_data=0, out_sat=0.
- Restart: first beat (sum=54), then first=last beat with taps=1, weights=1 -> only one out_valid, data=9.
- Reset mid-frame: assert s_rst_n=0 two cycles after a last beat, before its output -> out_valid never pulses, out_data=0. A fresh frame after release gives the correct result.
- Compile-time macro (CONV_KERNEL_RELU_EN): run the single-channel case with the macro defined -> ch0=9, ch1=0. Undefined -> ch1=-9. Also sweep OUT_CH=4, ACC_W=20 with a random-vector reference model.

Source files
------------

// File: rtl/conv_kernel_3x3_acc.sv
`default_nettype none
// ============================================================================
// Module   : conv_kernel_3x3_acc
// Brief    : OUT_CH parallel 3x3 signed dot products per window beat,
//            accumulated across input channels framed by first/last tags.
//            One saturated result per output channel per frame.
//            4-stage pipeline: products, row sums, 9-tap sum, accumulate.
// Options  : CONV_KERNEL_RELU_EN - when defined, negative results are
//            written out as zero (saturation flags unaffected).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module conv_kernel_3x3_acc #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int OUT_CH = 2,
  parameter int ACC_W  = 24
) (
  input  logic                        sclk,
  input  logic                        s_rst_n,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [9*DATA_W-1:0]         data_in,
  input  logic [OUT_CH*9*WGT_W-1:0]   weight_in,
  output logic                        out_valid,
  output logic [OUT_CH*ACC_W-1:0]     out_data,
  output logic [OUT_CH-1:0]           out_sat
);

  // Stage widths: product, row sum (3 terms), 9-tap sum, extended accumulator.
  localparam int c_PW = DATA_W + WGT_W;
  localparam int c_RW = c_PW + 2;
  localparam int c_SW = c_PW + 4;
  localparam int c_EW = ACC_W + 1;

  // Clamp bounds expressed at the extended width.
  localparam logic signed [c_EW-1:0] c_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [c_EW-1:0] c_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  // Valid and frame tags travelling alongside the data path.
  logic r_v1, r_v2, r_v3;
  logic r_f1, r_f2, r_f3;
  logic r_l1, r_l2, r_l3;
  logic r_ov;

  // Tag pipeline; tags are qualified by valid so idle beats carry no framing.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r_f1 <= 1'b0; r_f2 <= 1'b0; r_f3 <= 1'b0;
      r_l1 <= 1'b0; r_l2 <= 1'b0; r_l3 <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      r_f1 <= in_valid & in_first;
      r_l1 <= in_valid & in_last;
      r_v2 <= r_v1; r_f2 <= r_f1; r_l2 <= r_l1;
      r_v3 <= r_v2; r_f3 <= r_f2; r_l3 <= r_l2;
      r_ov <= r_v3 & r_l3;
    end
  end

  assign out_valid = r_ov;

  for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
    logic signed [c_PW-1:0]  r_prod [9];
    logic signed [c_RW-1:0]  r_row  [3];
    logic signed [c_SW-1:0]  r_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic signed [ACC_W-1:0] r_out;
    logic                    r_osat;

    logic signed [c_EW-1:0]  w_base;
    logic signed [c_EW-1:0]  w_raw;
    logic signed [c_EW-1:0]  w_clamped;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_acc_nx;
    logic                    w_sat_nx;
    logic signed [ACC_W-1:0] w_out_nx;

    // S1: nine signed tap products for this channel.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        for (int k = 0; k < 9; k++) r_prod[k] <= '0;
      end else begin
        for (int k = 0; k < 9; k++) begin
          r_prod[k] <= c_PW'($signed(data_in[k*DATA_W +: DATA_W]))
                     * c_PW'($signed(weight_in[(c*9+k)*WGT_W +: WGT_W]));
        end
      end
    end

    // S2: one partial sum per window row.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        for (int r = 0; r < 3; r++) r_row[r] <= '0;
      end else begin
        for (int r = 0; r < 3; r++) begin
          r_row[r] <= c_RW'(r_prod[3*r]) + c_RW'(r_prod[3*r+1])
                    + c_RW'(r_prod[3*r+2]);
        end
      end
    end

    // S3: full 9-tap sum.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        r_sum <= '0;
      end else begin
        r_sum <= c_SW'(r_row[0]) + c_SW'(r_row[1]) + c_SW'(r_row[2]);
      end
    end

    // S4 arithmetic: restart or accumulate at one extra bit, then clamp.
    always_comb begin
      w_base    = r_f3 ? '0 : c_EW'(r_acc);
      w_raw     = w_base + c_EW'(r_sum);
      w_clamped = w_raw;
      w_ovf     = 1'b0;
      if (w_raw > c_MAX) begin
        w_clamped = c_MAX;
        w_ovf     = 1'b1;
      end else if (w_raw < c_MIN) begin
        w_clamped = c_MIN;
        w_ovf     = 1'b1;
      end
      w_acc_nx = ACC_W'(w_clamped);
      w_sat_nx = (r_sat & ~r_f3) | w_ovf;
      w_out_nx = w_acc_nx;
`ifdef CONV_KERNEL_RELU_EN
      if (w_acc_nx[ACC_W-1]) w_out_nx = '0;
`endif
    end

    // S4 state: accumulator and sticky flag update; result capture on last.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        r_acc  <= '0;
        r_sat  <= 1'b0;
        r_out  <= '0;
        r_osat <= 1'b0;
      end else if (r_v3) begin
        r_acc <= w_acc_nx;
        r_sat <= w_sat_nx;
        if (r_l3) begin
          r_out  <= w_out_nx;
          r_osat <= w_sat_nx;
        end
      end
    end

    assign out_data[c*ACC_W +: ACC_W] = r_out;
    assign out_sat[c]                 = r_osat;
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_kernel_3x3_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_kernel_3x3_acc
// Brief    : Directed self-checking bench for conv_kernel_3x3_acc, default
//            configuration plus an OUT_CH=4 / ACC_W=20 instance driven with
//            random multi-beat frames against a behavioural reference.
//            Expectations follow CONV_KERNEL_RELU_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_kernel_3x3_acc;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic s_rst_n;

  // Default-parameter instance (OUT_CH=2, ACC_W=24).
  logic         in_valid, in_first, in_last;
  logic [71:0]  data_in;
  logic [143:0] weight_in;
  logic         out_valid;
  logic [47:0]  out_data;
  logic [1:0]   out_sat;

  // Wide instance (OUT_CH=4, ACC_W=20).
  logic         b_in_valid, b_in_first, b_in_last;
  logic [71:0]  b_data_in;
  logic [287:0] b_weight_in;
  logic         b_out_valid;
  logic [79:0]  b_out_data;
  logic [3:0]   b_out_sat;

  conv_kernel_3x3_acc u_dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  conv_kernel_3x3_acc #(.DATA_W(8), .WGT_W(8), .OUT_CH(4), .ACC_W(20)) u_dut_b (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .in_valid  (b_in_valid),
    .in_first  (b_in_first),
    .in_last   (b_in_last),
    .data_in   (b_data_in),
    .weight_in (b_weight_in),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_sat   (b_out_sat)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;

  // Reference state for the wide instance.
  int     tp [9];
  int     wt [4][9];
  longint macc [4];
  logic [3:0] msat;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge.
  task automatic tick();
    @(posedge sclk);
    #1;
    if (out_valid) n_pulses++;
  endtask

  task automatic set_beat(input logic v, input logic f, input logic l,
                          input int tap, input int w0, input int w1);
    in_valid = v; in_first = f; in_last = l;
    for (int k = 0; k < 9; k++) begin
      data_in[k*8 +: 8]        = 8'(tap);
      weight_in[k*8 +: 8]      = 8'(w0);
      weight_in[(9+k)*8 +: 8]  = 8'(w1);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  function automatic longint ch(input int c);
    logic signed [23:0] v;
    v = out_data[c*24 +: 24];
    return longint'(v);
  endfunction

  function automatic longint bch(input int c);
    logic signed [19:0] v;
    v = b_out_data[c*20 +: 20];
    return longint'(v);
  endfunction

  function automatic longint rl(input longint x);
`ifdef CONV_KERNEL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  initial begin
    s_rst_n = 1'b0;
    idle();
    data_in = '0; weight_in = '0;
    b_in_valid = 1'b0; b_in_first = 1'b0; b_in_last = 1'b0;
    b_data_in = '0; b_weight_in = '0;
    tick(); tick();

    // Reset state.
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_sat",   out_sat, 0);
    check("rst_b_valid", b_out_valid, 0);
    s_rst_n = 1'b1;
    tick();

    // Single-channel frame: 9 and -9, exact 4-cycle latency.
    n_pulses = 0;
    set_beat(1, 1, 1, 1, 1, -1); tick();
    idle(); tick(); tick();
    check("t1_not_early", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_ch0", ch(0), 9);
    check("t1_ch1", ch(1), rl(-9));
    check("t1_sat", out_sat, 0);
    tick();
    check("t1_pulse_end", out_valid, 0);
    check("t1_hold", ch(0), 9);

    // Three input channels with idle gaps: 3 * 54 = 162.
    n_pulses = 0;
    set_beat(1, 1, 0, 2, 3, 3); tick();
    idle(); tick();
    set_beat(1, 0, 0, 2, 3, 3); tick();
    idle(); tick();
    set_beat(1, 0, 1, 2, 3, 3); tick();
    idle(); tick(); tick();
    check("t2_not_early", out_valid, 0);
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_ch0", ch(0), 162);
    check("t2_ch1", ch(1), 162);
    tick();
    check("t2_one_pulse", n_pulses, 1);

    // Saturation: 60 beats of 147456 exceed 2^23-1 at beat 57.
    for (int i = 0; i < 60; i++) begin
      set_beat(1, i == 0, i == 59, -128, -128, -128);
      tick();
    end
    idle(); tick(); tick(); tick();
    check("t3_valid", out_valid, 1);
    check("t3_ch0", ch(0), 8388607);
    check("t3_ch1", ch(1), 8388607);
    check("t3_sat", out_sat, 3);
    // Next frame clears the sticky flag.
    set_beat(1, 1, 1, 0, -128, -128); tick();
    idle(); tick(); tick(); tick();
    check("t3b_valid", out_valid, 1);
    check("t3b_data", out_data, 0);
    check("t3b_sat", out_sat, 0);

    // Restart: open frame (54) discarded by a new first=last beat (9).
    n_pulses = 0;
    set_beat(1, 1, 0, 2, 3, 3); tick();
    set_beat(1, 1, 1, 1, 1, 1); tick();
    idle(); tick(); tick(); tick();
    check("t4_valid", out_valid, 1);
    check("t4_ch0", ch(0), 9);
    check("t4_ch1", ch(1), 9);
    tick(); tick(); tick();
    check("t4_one_pulse", n_pulses, 1);

    // Last without first accumulates onto the retained accumulator: 9 + 9.
    set_beat(1, 0, 1, 1, 1, 1); tick();
    idle(); tick(); tick(); tick();
    check("t4b_valid", out_valid, 1);
    check("t4b_ch0", ch(0), 18);

    // Reset two cycles after a last beat, before its output appears.
    n_pulses = 0;
    set_beat(1, 1, 1, 1, 1, 1); tick();
    idle(); tick();
    s_rst_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 0);
    tick(); tick();
    s_rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("t5_no_pulse", n_pulses, 0);
    check("t5_data_zero", out_data, 0);
    set_beat(1, 1, 1, 1, 1, -1); tick();
    idle(); tick(); tick(); tick();
    check("t5_fresh_valid", out_valid, 1);
    check("t5_fresh_ch0", ch(0), 9);
    check("t5_fresh_ch1", ch(1), rl(-9));

    // Wide instance: random 4-beat frames, two forced to clamp each way.
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 9; k++) begin
          if (f == 2)      tp[k] = -128;
          else if (f == 3) tp[k] = 127;
          else             tp[k] = int'($urandom_range(0, 255)) - 128;
          b_data_in[k*8 +: 8] = 8'(tp[k]);
        end
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 9; k++) begin
            if (f == 2 || f == 3) wt[c][k] = -128;
            else                  wt[c][k] = int'($urandom_range(0, 255)) - 128;
            b_weight_in[(c*9+k)*8 +: 8] = 8'(wt[c][k]);
          end
        end
        // Reference: restart on first, accumulate, clamp to 20-bit signed.
        for (int c = 0; c < 4; c++) begin
          longint s;
          s = 0;
          for (int k = 0; k < 9; k++) s += longint'(tp[k]) * longint'(wt[c][k]);
          if (b == 0) begin
            macc[c] = 0;
            msat[c] = 1'b0;
          end
          macc[c] += s;
          if (macc[c] > 524287) begin
            macc[c] = 524287; msat[c] = 1'b1;
          end else if (macc[c] < -524288) begin
            macc[c] = -524288; msat[c] = 1'b1;
          end
        end
        b_in_valid = 1'b1; b_in_first = (b == 0); b_in_last = (b == 3);
        tick();
      end
      b_in_valid = 1'b0; b_in_first = 1'b0; b_in_last = 1'b0;
      tick(); tick();
      check($sformatf("b%0d_not_early", f), b_out_valid, 0);
      tick();
      check($sformatf("b%0d_valid", f), b_out_valid, 1);
      for (int c = 0; c < 4; c++)
        check($sformatf("b%0d_ch%0d", f, c), bch(c), rl(macc[c]));
      check($sformatf("b%0d_sat", f), b_out_sat, msat);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
